// File: rtl/packet_receiver.sv
// Receiver for the 13-bit packet link: registered input stage, parity and sequence
// checks, a show-ahead FIFO toward a valid/ready sink, and saturating statistics counters.
module packet_receiver #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [12:0]      packet,
    input  logic             packet_valid,
    output logic [1:0]       out_dest,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             fifo_full,
    output logic [CNT_W-1:0] pkt_count,
    output logic [CNT_W-1:0] parity_err_count,
    output logic [CNT_W-1:0] seq_err_count,
    output logic [CNT_W-1:0] drop_count
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam int unsigned EW = 10;

    typedef enum logic {SYNC, LOCKED} state_t;

    state_t            state_q, state_d;
    logic [1:0]        exp_seq_q, exp_seq_d;
    logic              in_valid_q, in_valid_d;
    logic [12:0]       in_pkt_q, in_pkt_d;
    logic [EW-1:0]     mem_q [DEPTH];
    logic [EW-1:0]     mem_d [DEPTH];
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic              out_valid_q, out_valid_d;
    logic              fifo_full_q, fifo_full_d;
    logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
    logic [CNT_W-1:0]  par_cnt_q, par_cnt_d;
    logic [CNT_W-1:0]  seq_cnt_q, seq_cnt_d;
    logic [CNT_W-1:0]  drop_cnt_q, drop_cnt_d;

    logic              par_ok;
    logic              good;
    logic              pop;
    logic              push;
    logic [1:0]        seq;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    always_comb begin
        state_d     = state_q;
        exp_seq_d   = exp_seq_q;
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        pkt_cnt_d   = pkt_cnt_q;
        par_cnt_d   = par_cnt_q;
        seq_cnt_d   = seq_cnt_q;
        drop_cnt_d  = drop_cnt_q;
        in_valid_d  = packet_valid;
        in_pkt_d    = packet_valid ? packet : in_pkt_q;

        seq    = in_pkt_q[2:1];
        par_ok = ~(^in_pkt_q);
        good   = in_valid_q & par_ok;
        pop    = out_valid_q & out_ready;
        push   = good & (~fifo_full_q | pop);

        if (in_valid_q && !par_ok) begin
            par_cnt_d = sat_inc(par_cnt_q);
        end

        // Every good packet (delivered or dropped) resynchronises the expected sequence.
        if (good) begin
            exp_seq_d = seq + 2'd1;
            state_d   = LOCKED;
            if (state_q == LOCKED && seq != exp_seq_q) begin
                seq_cnt_d = sat_inc(seq_cnt_q);
            end
            if (push) begin
                mem_d[wr_ptr_q] = in_pkt_q[12:3];
                wr_ptr_d        = wr_ptr_q + AW'(1);
                pkt_cnt_d       = sat_inc(pkt_cnt_q);
            end else begin
                drop_cnt_d = sat_inc(drop_cnt_q);
            end
        end

        if (pop) begin
            rd_ptr_d = rd_ptr_q + AW'(1);
        end

        count_d     = count_q + CW'(push) - CW'(pop);
        out_valid_d = (count_d != CW'(0));
        fifo_full_d = (count_d == CW'(DEPTH));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= SYNC;
            exp_seq_q   <= 2'd0;
            in_valid_q  <= 1'b0;
            in_pkt_q    <= 13'd0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            out_valid_q <= 1'b0;
            fifo_full_q <= 1'b0;
            pkt_cnt_q   <= '0;
            par_cnt_q   <= '0;
            seq_cnt_q   <= '0;
            drop_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            exp_seq_q   <= exp_seq_d;
            in_valid_q  <= in_valid_d;
            in_pkt_q    <= in_pkt_d;
            mem_q       <= mem_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            out_valid_q <= out_valid_d;
            fifo_full_q <= fifo_full_d;
            pkt_cnt_q   <= pkt_cnt_d;
            par_cnt_q   <= par_cnt_d;
            seq_cnt_q   <= seq_cnt_d;
            drop_cnt_q  <= drop_cnt_d;
        end
    end

    assign {out_dest, out_data} = mem_q[rd_ptr_q];
    assign out_valid            = out_valid_q;
    assign fifo_full            = fifo_full_q;
    assign pkt_count            = pkt_cnt_q;
    assign parity_err_count     = par_cnt_q;
    assign seq_err_count        = seq_cnt_q;
    assign drop_count           = drop_cnt_q;
endmodule

// File: tb/tb_packet_receiver.sv
// Directed bench for packet_receiver: scoreboard queue of expected (dest,data) pairs
// checked as the sink accepts them, plus counter and flag checks between steps.
module tb_packet_receiver;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] packet = 13'd0;
    logic        packet_valid = 1'b0;
    logic [1:0]  out_dest;
    logic [7:0]  out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        fifo_full;
    logic [7:0]  pkt_count, parity_err_count, seq_err_count, drop_count;

    int total = 0;
    int bad   = 0;
    logic [9:0] sb [$];

    packet_receiver #(.DEPTH(4), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .packet(packet), .packet_valid(packet_valid),
        .out_dest(out_dest), .out_data(out_data), .out_valid(out_valid),
        .out_ready(out_ready), .fifo_full(fifo_full), .pkt_count(pkt_count),
        .parity_err_count(parity_err_count), .seq_err_count(seq_err_count),
        .drop_count(drop_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Sink-side scoreboard: every accepted beat must match the oldest expected entry.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                chk("unexpected_out", 32'({out_dest, out_data}), 32'h3ff);
            end else begin
                chk("out_beat", 32'({out_dest, out_data}), 32'(sb.pop_front()));
            end
        end
    end

    function automatic logic [12:0] mk(input logic [1:0] d, input logic [7:0] x,
                                       input logic [1:0] s);
        logic [11:0] h;
        h = {d, x, s};
        return {h, ^h};
    endfunction

    task automatic drive(input logic [12:0] p);
        packet       = p;
        packet_valid = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic idle(input int n);
        packet_valid = 1'b0;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        packet_valid = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        sb.delete();
    endtask

    task automatic wait_drain(input int budget);
        int n;
        n = 0;
        while (sb.size() != 0 && n < budget) begin
            @(posedge clk);
            n++;
        end
        #1;
        chk("drain_done", 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_full"}, 32'(fifo_full), 32'd0);
        chk({tag, "_dd"}, 32'({out_dest, out_data}), 32'd0);
        chk({tag, "_pkt"}, 32'(pkt_count), 32'd0);
        chk({tag, "_par"}, 32'(parity_err_count), 32'd0);
        chk({tag, "_seq"}, 32'(seq_err_count), 32'd0);
        chk({tag, "_drop"}, 32'(drop_count), 32'd0);
    endtask

    initial begin
        logic [1:0] seqs [7];
        seqs = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd2, 2'd3};

        // Reset state
        do_reset();
        @(negedge clk);
        chk_reset_outputs("rst");

        // Single good beat, latency and delivery
        out_ready = 1'b1;
        sb.push_back({2'd1, 8'hA5});
        drive(13'h0D29);
        packet_valid = 1'b0;
        @(negedge clk);
        chk("lat_not_yet", 32'(out_valid), 32'd0);
        @(negedge clk);
        chk("lat_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("one_cycle_valid", 32'(out_valid), 32'd0);
        chk("t1_pkt", 32'(pkt_count), 32'd1);
        chk("t1_par", 32'(parity_err_count), 32'd0);
        chk("t1_seq", 32'(seq_err_count), 32'd0);

        // Parity error drop; FSM stays in SYNC
        do_reset();
        out_ready = 1'b1;
        drive(13'h0D28);
        idle(3);
        chk("par_cnt", 32'(parity_err_count), 32'd1);
        chk("par_pkt", 32'(pkt_count), 32'd0);
        chk("par_valid", 32'(out_valid), 32'd0);
        sb.push_back({2'd2, 8'h3C});
        drive(mk(2'd2, 8'h3C, 2'd2));
        idle(4);
        chk("sync_no_seqerr", 32'(seq_err_count), 32'd0);
        chk("sync_pkt", 32'(pkt_count), 32'd1);
        wait_drain(10);

        // Sequence stream 0,1,2,3,0,2,3
        do_reset();
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sb.push_back({2'(i), 8'(8'h10 + i)});
            drive(mk(2'(i), 8'(8'h10 + i), seqs[i]));
        end
        idle(4);
        wait_drain(20);
        chk("seq_err", 32'(seq_err_count), 32'd1);
        chk("seq_pkt", 32'(pkt_count), 32'd7);

        // Overflow with a stalled sink
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) begin
            if (i < 4) sb.push_back({2'(3 - (i % 4)), 8'(8'h40 + i)});
            drive(mk(2'(3 - (i % 4)), 8'(8'h40 + i), 2'(i)));
        end
        idle(3);
        chk("ovf_full", 32'(fifo_full), 32'd1);
        chk("ovf_drop", 32'(drop_count), 32'd2);
        chk("ovf_pkt", 32'(pkt_count), 32'd4);
        chk("ovf_seq", 32'(seq_err_count), 32'd0);
        out_ready = 1'b1;
        wait_drain(20);
        @(negedge clk);
        chk("ovf_empty", 32'(out_valid), 32'd0);
        chk("ovf_notfull", 32'(fifo_full), 32'd0);

        // Full FIFO: pop and push in the same cycle
        out_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sb.push_back({2'(i), 8'(8'h80 + i)});
            drive(mk(2'(i), 8'(8'h80 + i), 2'(i + 2)));
        end
        idle(3);
        chk("pp_full_before", 32'(fifo_full), 32'd1);
        sb.push_back({2'd1, 8'hEE});
        drive(mk(2'd1, 8'hEE, 2'd2));
        packet_valid = 1'b0;
        out_ready    = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        @(negedge clk);
        chk("pp_full_after", 32'(fifo_full), 32'd1);
        chk("pp_drop", 32'(drop_count), 32'd2);
        chk("pp_pkt", 32'(pkt_count), 32'd9);
        out_ready = 1'b1;
        wait_drain(20);

        // Parity counter saturation, then reset mid-stream
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 300; i++) begin
            drive(mk(2'(i), 8'(i), 2'(i)) ^ 13'h1);
        end
        for (int i = 0; i < 3; i++) begin
            drive(mk(2'd3, 8'(8'hC0 + i), 2'(i)));
        end
        idle(2);
        chk("sat_par", 32'(parity_err_count), 32'd255);
        chk("pre_rst_pkt", 32'(pkt_count), 32'd3);
        drive(mk(2'd2, 8'h55, 2'd3));
        rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        packet_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        idle(4);
        chk("post_rst_valid", 32'(out_valid), 32'd0);
        chk("post_rst_pkt", 32'(pkt_count), 32'd0);
        chk("sb_empty", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/packet_receiver.md
# packet_receiver

Receiving end of the 13-bit packet link. Samples `packet`/`packet_valid` from the packet generator every clock and decodes each beat into destination, data and sequence fields. It checks even parity and sequence continuity, buffers good packets in a small FIFO, and presents them to a downstream sink over a valid/ready handshake. Saturating statistics counters expose link health to the control path.

## Interface
- `DEPTH`, 4: FIFO entries; power of two, ≥2.
- `CNT_W`, 8: width of each statistics counter.

- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `packet`  in  13  incoming packet; valid only when `packet_valid`=1.
- `packet_valid`  in  1  one packet per cycle while high.
- `out_dest`  out  2  head-of-FIFO destination field.
- `out_data`  out  8  head-of-FIFO data field.
- `out_valid`  out  1  FIFO non-empty.
- `out_ready`  in  1  sink accepts head when `out_valid`&`out_ready`.
- `fifo_full`  out  1  FIFO holds DEPTH entries.
- `pkt_count`  out  CNT_W  packets written to FIFO.
- `parity_err_count`  out  CNT_W  packets dropped for bad parity.
- `seq_err_count`  out  CNT_W  sequence discontinuities.
- `drop_count`  out  CNT_W  good packets lost to overflow.

## Operation
- Packet format: [12:11] dest, [10:3] data, [2:1] seq, [0] even parity. The XOR of all 13 bits must be 0.
- Input stage: registered. The decode/check happens on the cycle `packet_valid` is sampled high. Cycles with `packet_valid`=0 are ignored entirely, whatever the value of `packet`.
- Parity failure: increments `parity_err_count` and drops the packet. No FIFO write, no sequence update, no state change.
- Sequence FSM:
  - States: SYNC (reset state) and LOCKED.
  - SYNC + parity-good packet: set expected seq = seq+1 mod 4, go to LOCKED, no seq error.
  - LOCKED + good packet with seq == expected: expected = expected+1 mod 4.
  - LOCKED + good packet with seq != expected: increment `seq_err_count` and resync expected = seq+1 mod 4. The packet is still delivered.
  - Wrap 3→0 is legal continuity.
- FIFO write (dest, data) for every parity-good packet:
  - Write is allowed if not full, or if a pop occurs in the same cycle.
  - Otherwise increment `drop_count`; `pkt_count` is not incremented.
  - Sequence tracking still updates on an overflow drop.
- FIFO read:
  - Show-ahead: `out_dest`/`out_data` reflect the head whenever `out_valid`=1.
  - Pop on `out_valid`&`out_ready`.
  - `out_dest`/`out_data` are don't-care when empty. The bench must not check them then.
- Counters saturate at 2^CNT_W−1 and never wrap.
- Simultaneous push+pop when empty: the push happens and `out_valid` rises next cycle. The pop is ignored because `out_valid` was 0.

## Timing
- Reset (async assert, sync-safe deassert):
  - FSM = SYNC; FIFO empty.
  - `out_valid`=0, `fifo_full`=0, all counters=0.
  - `out_dest`/`out_data`=0.
- Latency: a packet sampled at edge N appears at `out_valid`=1 after edge N+1 (2 edges, input register + FIFO write).
- Counters update at the same edge as the corresponding FIFO write/drop decision, i.e. edge N+1.
- Throughput: one packet per cycle in and out. A continuously ready sink with DEPTH≥2 never causes drops.
- `fifo_full`/`out_valid` are registered-state derived with no combinational path from `packet_valid`. `out_valid` has no combinational path from `out_ready`.
- Reset mid-stream: the in-flight input register and FIFO contents are discarded, and the FSM returns to SYNC.

## Test plan
- Reset, then one beat `packet`=13'h0D29 (dest 1, data A5, seq 0, parity ok) with `out_ready`=1 → `out_valid` for 1 cycle with `out_dest`=1, `out_data`=8'hA5; `pkt_count`=1; error counters 0.
- Same beat with bit 0 flipped (13'h0D28) → no `out_valid`; `parity_err_count`=1; FSM stays SYNC, so the next good packet with any seq causes no seq error.
- Seq stream 0,1,2,3,0,2,3, all parity-good → 7 packets delivered; `seq_err_count`=1 (at the 2); following 3 gives no error.
- `out_ready`=0, 6 consecutive good packets, DEPTH=4 → `fifo_full`=1 after the 4th write; `drop_count`=2; `pkt_count`=4. Then `out_ready`=1 drains exactly the first 4 packets in order.
- FIFO full, `out_ready`=1 and a new good packet arrive in the same cycle → head popped and new packet written; `drop_count` unchanged; `fifo_full` stays 1.
- 300 bad-parity packets → `parity_err_count` saturates at 255. Assert `rst` mid-burst → all outputs return to reset values immediately.
